// File: rtl/cnn_pkg.sv
// Shared types and dimensions for the CNN front-end blocks.
package cnn_pkg;
  typedef logic signed [7:0] pixel_t;

  localparam int KSIZE         = 5;
  localparam int IMG_W_DEFAULT = 28;
  localparam int IMG_H_DEFAULT = 28;
endpackage

// File: rtl/conv_line_fifo.sv
// Single-row delay line: the output is the pixel pushed DEPTH pushes ago.
module conv_line_fifo
  import cnn_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (push) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
    end
  end

  // Storage is deliberately not reset; stale rows are masked by window gating.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr] <= din;
    end
  end

  assign dout = mem[ptr];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 5x5 window generator with four line buffers.
// Define CONV_WIN_OFFSET_EN to convert unsigned input pixels to signed (MSB inverted).
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEFAULT,
  parameter int IMG_H = IMG_H_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pixel_valid,
  input  logic [7:0]        pixel_in,
  input  logic              sof,
  output logic signed [7:0] data_out_0,
  output logic signed [7:0] data_out_1,
  output logic signed [7:0] data_out_2,
  output logic signed [7:0] data_out_3,
  output logic signed [7:0] data_out_4,
  output logic signed [7:0] data_out_5,
  output logic signed [7:0] data_out_6,
  output logic signed [7:0] data_out_7,
  output logic signed [7:0] data_out_8,
  output logic signed [7:0] data_out_9,
  output logic signed [7:0] data_out_10,
  output logic signed [7:0] data_out_11,
  output logic signed [7:0] data_out_12,
  output logic signed [7:0] data_out_13,
  output logic signed [7:0] data_out_14,
  output logic signed [7:0] data_out_15,
  output logic signed [7:0] data_out_16,
  output logic signed [7:0] data_out_17,
  output logic signed [7:0] data_out_18,
  output logic signed [7:0] data_out_19,
  output logic signed [7:0] data_out_20,
  output logic signed [7:0] data_out_21,
  output logic signed [7:0] data_out_22,
  output logic signed [7:0] data_out_23,
  output logic signed [7:0] data_out_24,
  output logic              valid_out_buf,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KSIZE - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KSIZE - 1);

  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic [7:0]    pix;

  // tap[0] is the incoming pixel, tap[k] the same column k rows earlier
  logic [KSIZE-1:0][7:0] tap;
  pixel_t win [KSIZE][KSIZE];

`ifdef CONV_WIN_OFFSET_EN
  assign pix = pixel_in ^ 8'h80;
`else
  assign pix = pixel_in;
`endif

  assign tap[0] = pix;

  for (genvar i = 0; i < KSIZE - 1; i++) begin : g_line
    conv_line_fifo #(.DEPTH(IMG_W)) u_line (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (pixel_valid),
      .din   (tap[i]),
      .dout  (tap[i+1])
    );
  end

  always_comb begin
    cur_col = col;
    cur_row = row;
    if (sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col           <= '0;
      row           <= '0;
      valid_out_buf <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      valid_out_buf <= pixel_valid && (cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST);
      frame_done    <= pixel_valid && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      if (pixel_valid) begin
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
      end
    end
  end

  // Row 0 of the window is the oldest line, column KSIZE-1 the newest pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (pixel_valid) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][KSIZE-1] <= pixel_t'(tap[KSIZE-1-r]);
      end
    end
  end

  assign data_out_0  = win[0][0];
  assign data_out_1  = win[0][1];
  assign data_out_2  = win[0][2];
  assign data_out_3  = win[0][3];
  assign data_out_4  = win[0][4];
  assign data_out_5  = win[1][0];
  assign data_out_6  = win[1][1];
  assign data_out_7  = win[1][2];
  assign data_out_8  = win[1][3];
  assign data_out_9  = win[1][4];
  assign data_out_10 = win[2][0];
  assign data_out_11 = win[2][1];
  assign data_out_12 = win[2][2];
  assign data_out_13 = win[2][3];
  assign data_out_14 = win[2][4];
  assign data_out_15 = win[3][0];
  assign data_out_16 = win[3][1];
  assign data_out_17 = win[3][2];
  assign data_out_18 = win[3][3];
  assign data_out_19 = win[3][4];
  assign data_out_20 = win[4][0];
  assign data_out_21 = win[4][1];
  assign data_out_22 = win[4][2];
  assign data_out_23 = win[4][3];
  assign data_out_24 = win[4][4];

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: ramp, gapped, abort, reset and constant frames.
module tb_conv_window_gen;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int NWIN = (W - 4) * (H - 4);
`ifdef CONV_WIN_OFFSET_EN
  localparam logic [7:0] CVAL = 8'h00;
  localparam logic [7:0] CEXP = 8'h80;
`else
  localparam logic [7:0] CVAL = 8'hFF;
  localparam logic [7:0] CEXP = 8'hFF;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pixel_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] pixel_in = 8'h00;
  logic signed [7:0] d [25];
  logic       valid_out_buf, frame_done;

  int total = 0;
  int bad   = 0;
  logic [199:0] exp_q [$];
  logic exp_valid = 1'b0, exp_done = 1'b0, exp_hold = 1'b0;
  logic first_chk = 1'b0, const_chk = 1'b0;
  int   win_cnt = 0, done_cnt = 0;
  logic [199:0] dut_win, last_win;
  logic [7:0] img [H][W];
  int mr = 0, mc = 0;

  conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_valid(pixel_valid), .pixel_in(pixel_in), .sof(sof),
    .data_out_0(d[0]),   .data_out_1(d[1]),   .data_out_2(d[2]),   .data_out_3(d[3]),
    .data_out_4(d[4]),   .data_out_5(d[5]),   .data_out_6(d[6]),   .data_out_7(d[7]),
    .data_out_8(d[8]),   .data_out_9(d[9]),   .data_out_10(d[10]), .data_out_11(d[11]),
    .data_out_12(d[12]), .data_out_13(d[13]), .data_out_14(d[14]), .data_out_15(d[15]),
    .data_out_16(d[16]), .data_out_17(d[17]), .data_out_18(d[18]), .data_out_19(d[19]),
    .data_out_20(d[20]), .data_out_21(d[21]), .data_out_22(d[22]), .data_out_23(d[23]),
    .data_out_24(d[24]),
    .valid_out_buf(valid_out_buf), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always_comb begin
    dut_win = '0;
    for (int k = 0; k < 25; k++) dut_win[k*8 +: 8] = d[k];
  end

  function automatic logic [7:0] xf(input logic [7:0] p);
`ifdef CONV_WIN_OFFSET_EN
    return p ^ 8'h80;
`else
    return p;
`endif
  endfunction

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_win", dut_win, '0);
      chk("reset_valid", 200'(valid_out_buf), '0);
      chk("reset_done", 200'(frame_done), '0);
    end else begin
      chk("valid", 200'(valid_out_buf), 200'(exp_valid));
      chk("frame_done", 200'(frame_done), 200'(exp_done));
      if (exp_hold) chk("hold", dut_win, last_win);
      if (valid_out_buf) begin
        win_cnt++;
        chk("queue_nonempty", 200'(exp_q.size() != 0), 200'd1);
        if (exp_q.size() != 0) chk("window", dut_win, exp_q.pop_front());
        if (first_chk) begin
          chk("first_d0",  200'($unsigned(d[0])),  200'(xf(8'd0)));
          chk("first_d4",  200'($unsigned(d[4])),  200'(xf(8'd4)));
          chk("first_d20", 200'($unsigned(d[20])), 200'(xf(8'd112)));
          chk("first_d24", 200'($unsigned(d[24])), 200'(xf(8'd116)));
          first_chk = 1'b0;
        end
        if (const_chk) chk("const_window", dut_win, {25{CEXP}});
      end
      if (frame_done) done_cnt++;
    end
    last_win = dut_win;
  end

  // Drive one cycle, update the reference raster model, and queue any expected window.
  task automatic cycle(input logic v, input logic [7:0] p, input logic s);
    logic [199:0] w;
    int re, ce;
    logic ev, ed;
    ev = 1'b0;
    ed = 1'b0;
    w  = '0;
    pixel_valid = v;
    pixel_in    = p;
    sof         = s;
    if (v) begin
      re = s ? 0 : mr;
      ce = s ? 0 : mc;
      img[re][ce] = xf(p);
      if (re >= 4 && ce >= 4) begin
        for (int k = 0; k < 25; k++) w[k*8 +: 8] = img[re-4+k/5][ce-4+k%5];
        exp_q.push_back(w);
        ev = 1'b1;
      end
      ed = (re == H - 1) && (ce == W - 1);
      if (ce == W - 1) begin
        mc = 0;
        mr = (re == H - 1) ? 0 : re + 1;
      end else begin
        mc = ce + 1;
        mr = re;
      end
    end
    @(posedge clk);
    #1;
    exp_valid = ev;
    exp_done  = ed;
    exp_hold  = !v;
  endtask

  task automatic send_pixels(input logic use_const, input logic gaps, input logic sof_first, input int npix);
    logic [7:0] p;
    for (int i = 0; i < npix; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) cycle(1'b0, 8'h00, 1'b0);
      p = use_const ? CVAL : 8'(i);
      cycle(1'b1, p, sof_first && (i == 0));
    end
  endtask

  task automatic frame_check(input string tag, input int nwin, input int ndone);
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    chk({tag, "_windows"}, 200'(win_cnt), 200'(nwin));
    chk({tag, "_done"}, 200'(done_cnt), 200'(ndone));
    chk({tag, "_queue_empty"}, 200'(exp_q.size()), '0);
    win_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    pixel_valid = 1'b0;
    sof         = 1'b0;
    mr = 0;
    mc = 0;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    exp_hold = 1'b1;
    win_cnt  = 0;
    done_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    do_reset();

    first_chk = 1'b1;
    send_pixels(1'b0, 1'b0, 1'b0, W * H);
    frame_check("ramp", NWIN, 1);

    first_chk = 1'b1;
    send_pixels(1'b0, 1'b1, 1'b0, W * H);
    frame_check("gapped", NWIN, 1);

    // 300 pixels reach (10,19): 6 full window rows plus 16 windows on row 10
    first_chk = 1'b1;
    send_pixels(1'b0, 1'b0, 1'b0, 300);
    frame_check("pre_abort", 6 * 24 + 16, 0);
    first_chk = 1'b1;
    send_pixels(1'b0, 1'b0, 1'b1, W * H);
    frame_check("after_sof", NWIN, 1);

    first_chk = 1'b1;
    send_pixels(1'b0, 1'b0, 1'b0, 400);
    do_reset();
    repeat (2) cycle(1'b0, 8'h00, 1'b0);
    first_chk = 1'b1;
    send_pixels(1'b0, 1'b0, 1'b0, W * H);
    frame_check("after_reset", NWIN, 1);

    const_chk = 1'b1;
    send_pixels(1'b1, 1'b0, 1'b0, W * H);
    frame_check("const", NWIN, 1);
    const_chk = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 5x5 window generator that feeds the depthwise separable convolution stage. It accepts a raster-order pixel stream, one pixel per accepted cycle. It holds the last four image rows in line buffers and presents a complete 5x5 neighbourhood on `data_out_0..data_out_24`, qualified by a one-cycle `valid_out_buf` pulse. It sits between the image loader and `depthwise_separable_conv1`, and produces one window per valid (stride 1, no padding) output position.

## Interface
- `IMG_W`, 28: image width in pixels (≥ 5)
- `IMG_H`, 28: image height in pixels (≥ 5)
- `clk`  in  1: single clock, rising edge
- `rst_n`  in  1: asynchronous, active-low reset
- `pixel_valid`  in  1: `pixel_in` is accepted this cycle
- `pixel_in`  in  8: pixel value
- `sof`  in  1: start of frame; only meaningful with `pixel_valid`
- `data_out_0` … `data_out_24`  out  8 signed each: window, index = r*5+c; r=0 oldest row, c=0 oldest column; `data_out_24` is the newest pixel
- `valid_out_buf`  out  1: window valid, one-cycle pulse per window
- `frame_done`  out  1: one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on accepted pixels.
  - `col` wraps to 0 and increments `row`.
  - `row` wraps to 0 after IMG_H-1.
- `sof` with `pixel_valid` forces that pixel to position (0,0), regardless of the current counts.
- Each accepted pixel does two things:
  - It is pushed into line buffer 0. The output of line buffer k feeds line buffer k+1, with 4 buffers each IMG_W deep.
  - The five vertically aligned pixels (the current pixel plus the 4 buffer outputs) shift into the right column of a 5x5 register window. Every window column moves one place left.
- `valid_out_buf` is registered and goes high the cycle after accepting a pixel with `row ≥ 4` and `col ≥ 4`. Otherwise it is 0.
  - This gives (IMG_W-4)*(IMG_H-4) windows per frame; 576 for 28x28.
- Windows whose columns straddle a row wrap are never flagged valid. Their contents are don't-care.
- `frame_done` pulses the cycle after accepting pixel (IMG_H-1, IMG_W-1).
- Line buffer contents are not cleared between frames. Valid gating makes stale rows irrelevant.
- Arithmetic: `pixel_in` is reinterpreted as signed 8-bit unless the offset feature is enabled (see Configuration). No width growth occurs.

## Timing
- Latency: the pixel accepted in cycle N appears as `data_out_24` in cycle N+1, together with `valid_out_buf` when qualifying.
- Window outputs hold their values while `pixel_valid` is low. `valid_out_buf` is high for exactly one cycle per window.
- Throughput is 1 window/cycle with back-to-back `pixel_valid`. Gaps are allowed anywhere, with no effect except delay.
- There is no backpressure; the downstream stage must consume combinationally within the valid cycle.
- Reset values:
  - `valid_out_buf`=0, `frame_done`=0
  - all `data_out_*`=0
  - `row`=`col`=0
  - line buffer read/write pointers=0
- Reset mid-frame: all of the above apply immediately. The next accepted pixel is treated as (0,0).
- `sof` on a pixel accepted at (r,c)≠(0,0) aborts the current frame. No `frame_done` is emitted for the aborted frame.
- `sof` on the pixel completing a window position does not produce a window for the old frame.

## Configuration
- `CONV_WIN_OFFSET_EN` defined:
  - Each accepted pixel is converted from unsigned to signed by subtracting 128 (MSB inverted) before buffering.
  - 0x00 → -128, 0xFF → +127.
- Not defined: bits pass through unchanged (0xFF → -1).

## Structure
- The shared package `cnn_pkg` holds:
  - `pixel_t` (logic signed [7:0])
  - `KSIZE`=5
  - default `IMG_W`/`IMG_H`=28
- Sub-module `conv_line_fifo`: single-row delay line with IMG_W depth, one write/read per push, circular pointer wrap at IMG_W-1. Instantiated 4 times.
- The window registers, counters and valid/done logic live in the top module.

## Test plan
- 28x28 ramp, pixel = (row*28+col) mod 256, continuous valid → first `valid_out_buf` one cycle after accepting pixel index 116. At that cycle:
  - `data_out_0`=0, `data_out_4`=4
  - `data_out_20`=112, `data_out_24`=116
- Full ramp frame → exactly 576 `valid_out_buf` pulses and 1 `frame_done`, the latter one cycle after pixel 783.
- Same frame with random 0-3 idle cycles between pixels → identical sequence of windows. Outputs stable during gaps.
- `sof` asserted at pixel 300, followed by a fresh frame → no window from the old frame after the abort. The new frame yields 576 windows, the first matching the ramp check.
- `rst_n` pulsed low at pixel 400, then a new frame → all outputs 0 during reset. The next frame produces 576 correct windows.
- `CONV_WIN_OFFSET_EN` defined, constant input 0x00 → every valid window has all 25 outputs = -128. Undefined, input 0xFF → all outputs = -1.
